// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and controller encodings for the message sequencer and core.
package sha256_pkg;

  localparam int unsigned BLOCK_W     = 512;
  localparam int unsigned DIGEST_W    = 256;
  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned PAD_THRESH  = 55;
  localparam int unsigned LEN_BITS    = 64;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  localparam logic [DIGEST_W-1:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_DONE,
    ST_OUT
  } state_t;

  typedef enum logic [1:0] {
    AFT_FILL,
    AFT_LEN,
    AFT_OUT
  } after_t;

endpackage

// File: rtl/sha256_pad_block.sv
// Builds the final padded block and the optional length-only block from a partial buffer.
module sha256_pad_block
  import sha256_pkg::*;
(
  input  logic [BLOCK_W-1:0]  blk_buf,
  input  logic [6:0]          p,
  input  logic [LEN_BITS-1:0] bitlen,
  output logic [BLOCK_W-1:0]  final_blk,
  output logic [BLOCK_W-1:0]  len_blk,
  output logic                need_len
);

  always_comb begin
    final_blk = '0;
    len_blk   = '0;
    need_len  = (p > 7'(PAD_THRESH));
    // Keep message bytes below p, marker at p, zeros above (stale buffer bytes masked).
    for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
      if (7'(i) < p) begin
        final_blk[BLOCK_W-1-8*i -: 8] = blk_buf[BLOCK_W-1-8*i -: 8];
      end else if (7'(i) == p) begin
        final_blk[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
      end
    end
    if (!need_len) begin
      final_blk[LEN_BITS-1:0] = bitlen;
    end
    len_blk[LEN_BITS-1:0] = bitlen;
    // A completely full buffer leaves no room for the marker, so it opens the length block.
    if (p == 7'(BLOCK_BYTES)) begin
      len_blk[BLOCK_W-1 -: 8] = PAD_BYTE;
    end
  end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Byte-stream front end for sha256_core: block assembly, padding, chaining and digest handoff.
module sha256_msg_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                dig_valid,
  input  logic                dig_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                busy,
  output logic                core_start,
  output logic [BLOCK_W-1:0]  core_block,
  output logic [DIGEST_W-1:0] core_hash_init,
  output logic                core_use_init,
  input  logic [DIGEST_W-1:0] core_hash_out,
  input  logic                core_ready
);

  localparam int unsigned CNT_W = LEN_W - 3;

  state_t               state;
  after_t               after;
  logic [5:0]           idx;
  logic [6:0]           p;
  logic [CNT_W-1:0]     byte_cnt;
  logic                 first;
  logic [BLOCK_W-1:0]   blk_buf;
  logic [DIGEST_W-1:0]  chain;

  logic [LEN_W-1:0]     bitlen_full;
  logic [LEN_BITS-1:0]  bitlen;
  logic [BLOCK_W-1:0]   final_blk;
  logic [BLOCK_W-1:0]   len_blk;
  logic                 need_len;
  logic                 accept;

  assign bitlen_full = {byte_cnt, 3'b000};
  assign bitlen      = LEN_BITS'(bitlen_full);
  assign accept      = in_valid & in_ready;

  sha256_pad_block u_pad (
    .blk_buf   (blk_buf),
    .p         (p),
    .bitlen    (bitlen),
    .final_blk (final_blk),
    .len_blk   (len_blk),
    .need_len  (need_len)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      after          <= AFT_FILL;
      idx            <= '0;
      p              <= '0;
      byte_cnt       <= '0;
      first          <= 1'b1;
      blk_buf        <= '0;
      chain          <= '0;
      in_ready       <= 1'b0;
      dig_valid      <= 1'b0;
      digest         <= '0;
      busy           <= 1'b0;
      core_start     <= 1'b0;
      core_block     <= '0;
      core_hash_init <= '0;
      core_use_init  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          state    <= ST_FILL;
        end

        ST_FILL: begin
          if (accept) begin
            for (int i = 0; i < int'(BLOCK_BYTES); i++) begin
              if (idx == 6'(i)) blk_buf[BLOCK_W-1-8*i -: 8] <= in_data;
            end
            idx      <= idx + 6'd1;
            byte_cnt <= byte_cnt + CNT_W'(1);
            busy     <= 1'b1;
            if (in_last) begin
              p        <= 7'(idx) + 7'd1;
              in_ready <= 1'b0;
              state    <= ST_PAD;
            end else if (idx == 6'd63) begin
              // The byte landing this cycle is not in blk_buf yet, so splice it in directly.
              in_ready       <= 1'b0;
              core_block     <= {blk_buf[BLOCK_W-1:8], in_data};
              core_hash_init <= chain;
              core_use_init  <= ~first;
              core_start     <= 1'b1;
              after          <= AFT_FILL;
              state          <= ST_ISSUE;
            end
          end
        end

        ST_PAD: begin
          core_block     <= final_blk;
          core_hash_init <= chain;
          core_use_init  <= ~first;
          core_start     <= 1'b1;
          after          <= need_len ? AFT_LEN : AFT_OUT;
          state          <= ST_ISSUE;
        end

        ST_ISSUE: begin
          core_start <= 1'b0;
          state      <= ST_WAIT_LOW;
        end

        // core_ready may still be high from the previous block here.
        ST_WAIT_LOW: begin
          state <= ST_WAIT_DONE;
        end

        ST_WAIT_DONE: begin
          if (core_ready) begin
            chain <= core_hash_out;
            first <= 1'b0;
            case (after)
              AFT_FILL: begin
                idx      <= '0;
                in_ready <= 1'b1;
                state    <= ST_FILL;
              end
              AFT_LEN: begin
                core_block     <= len_blk;
                core_hash_init <= core_hash_out;
                core_use_init  <= 1'b1;
                core_start     <= 1'b1;
                after          <= AFT_OUT;
                state          <= ST_ISSUE;
              end
              default: begin
                digest    <= core_hash_out;
                dig_valid <= 1'b1;
                state     <= ST_OUT;
              end
            endcase
          end
        end

        ST_OUT: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            busy      <= 1'b0;
            idx       <= '0;
            byte_cnt  <= '0;
            first     <= 1'b1;
            in_ready  <= 1'b1;
            state     <= ST_FILL;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Byte-stream front end and sequencer for sha256_core. It accepts an arbitrary-length message of at least one byte and assembles 512-bit blocks. It applies FIPS 180-4 padding and the big-endian bit length. It issues each block to the core with correct chaining (use_init/hash_init) and presents the final 256-bit digest on a valid/ready output. It sits between the host byte interface and a single sha256_core instance.

Parameters:
LEN_W, 64, width of the message bit-length field. The internal byte counter is LEN_W-3 bits and wraps modulo 2^(LEN_W-3).

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
in_valid  in  1  message byte valid
in_data  in  8  message byte, first byte = MSB of the first word
in_last  in  1  marks the final byte of the message
in_ready  out  1  byte accepted when in_valid & in_ready
dig_valid  out  1  digest available
dig_ready  in  1  digest consumed when dig_valid & dig_ready
digest  out  256  H0..H7, H0 in [255:224]
busy  out  1  high from the first accepted byte until the digest handshake
core_start  out  1  one-cycle start pulse to the core
core_block  out  512  block to the core; byte 0 in [511:504]
core_hash_init  out  256  chaining value for the core
core_use_init  out  1  0 = first block (IV), 1 = chain
core_hash_out  in  256  core result
core_ready  in  1  core done flag

Behaviour:
- Reset (async): state IDLE. All outputs 0: in_ready, dig_valid, digest, busy, core_start, core_block, core_hash_init, core_use_init. Byte index, byte counter and first-block flag are cleared (first=1).
- IDLE -> FILL unconditionally on the next clk.
- FILL: in_ready=1. Each accepted byte is written at byte index idx (0..63); idx increments and the byte counter increments. busy goes 1 on the first byte.
  - Byte accepted at idx 63 without in_last: go to ISSUE, then FILL (after=FILL).
  - Byte accepted with in_last: go to PAD; the pad position p is the byte count in the buffer (1..64).
- PAD (1 cycle, in_ready=0): build the final block(s).
  - p<=55: byte p=0x80, bytes p+1..55 =0, bytes 56..63 = bitlen. Go to ISSUE, after=OUT.
  - 56<=p<=63: byte p=0x80, remaining bytes 0. Go to ISSUE, after=LEN. LEN block = zeros with bitlen in bytes 56..63.
  - p=64: issue the full buffer first. The LEN block then has byte 0=0x80.
- bitlen = byte_count<<3, zero-extended/truncated to 64 bits, big-endian.
- ISSUE: core_start=1 for exactly one cycle. core_use_init = !first, and core_hash_init = the last captured core_hash_out. core_block and core_hash_init are held stable from ISSUE until the WAIT_DONE exit.
- Go to WAIT_LOW (1 cycle): core_ready is ignored, because it is stale-high from the prior block or undefined after reset. Then go to WAIT_DONE.
- WAIT_DONE: on core_ready=1, capture core_hash_out into the chain register and clear first. Then:
  - after=FILL: go to FILL with idx=0.
  - after=LEN: load the LEN block, go to ISSUE, after=OUT.
  - after=OUT: digest<=core_hash_out, dig_valid=1, go to OUT.
- core_start is always 0 in WAIT_DONE, so the core can leave DONE.
- OUT: in_ready=0. digest is held stable while dig_valid=1. On dig_ready: dig_valid=0, busy=0, counters and first are cleared, go to FILL. dig_ready asserted in the same cycle dig_valid rises completes immediately.
- Only one message is in flight at a time. No new bytes are accepted until the digest handshake.
- in_valid outside FILL is ignored; bytes are not lost because in_ready=0.
- rst mid-operation aborts the message and returns to IDLE. The core must be reset by the same rst (its own sync reset).
- Latency per block = 3 controller cycles + core latency. The core is never restarted before core_ready.

Decomposition:
- sha256_pkg holds:
  - state encoding (IDLE, FILL, PAD, ISSUE, WAIT_LOW, WAIT_DONE, OUT)
  - after-codes (FILL, LEN, OUT)
  - BLOCK_W=512, DIGEST_W=256, the 0x80 pad byte, the pad threshold 55
  - the IV constants, shared with sha256_core
- One combinational sub-module, sha256_pad_block: inputs are the buffer, p and bitlen; outputs are the final block, the LEN block and the need_len flag.

Test Plan:
- "abc" (3 bytes, last on 'c') -> one core_start; digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (56 bytes) -> two core_starts, second with use_init=1; digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- 64 and 119 bytes of 0x61 -> 2 core_starts each. For 64 bytes the LEN block byte 0 = 0x80, bitlen = 0x200. Digest matches the software model.
- Random in_valid gaps plus dig_ready held low for 20 cycles -> digest stable, in_ready=0 throughout, no byte dropped. After dig_ready: in_ready=1 next cycle.
- Core stub holding core_ready=1 before start -> no premature capture; the controller waits for ready to fall and then rise.
- rst pulsed mid-block (and mid-WAIT_DONE) -> all outputs 0 immediately. A following "abc" yields the correct digest with use_init=0.
